// File: rtl/uart_pkg.sv
// uart_pkg: shared UART line levels, transmit FSM states and xmodem control bytes.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;

   localparam logic [7:0] SOH     = 8'h01;
   localparam logic [7:0] EOT     = 8'h04;
   localparam logic [7:0] ACK     = 8'h06;
   localparam logic [7:0] NAK     = 8'h15;
   localparam logic [7:0] ASCII_C = 8'h43;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: CLKS_PER_BIT divider with synchronous clear; bit_end marks the
// last cycle of each bit period.
module uart_baud_tick #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_end
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign bit_end = (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: double-buffered parametrised UART transmitter.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned MSB_FIRST    = 0,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
       (STOP_BITS != 1 && STOP_BITS != 2) || MSB_FIRST > 1 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("uart_tx_frame: illegal parameter set");
   end

   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] FIRST_IDX = (MSB_FIRST != 0) ? IDX_W'(DATA_BITS - 1) : '0;
   localparam logic [IDX_W-1:0] LAST_IDX  = (MSB_FIRST != 0) ? '0 : IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_t          state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] hold_q, shift_q;
   logic                 hold_full;
   logic                 load, done_d, line_d;
   logic                 baud_clr, bit_end;
`ifdef UART_TX_PARITY_EN
   logic                 par_q;
`endif

   assign ready    = ~hold_full;
   assign baud_clr = (state_q == IDLE);

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clr     (baud_clr),
      .bit_end (bit_end)
   );

   // line_d reflects the current state; tx registers it, so tx trails state by one cycle
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      stop_d  = stop_q;
      load    = 1'b0;
      done_d  = 1'b0;
      line_d  = LINE_IDLE;
      case (state_q)
         IDLE: begin
            if (hold_full) begin
               load    = 1'b1;
               state_d = START;
            end
         end
         START: begin
            line_d = START_LVL;
            if (bit_end) begin
               state_d = DATA;
               idx_d   = FIRST_IDX;
            end
         end
         DATA: begin
            line_d = shift_q[idx_q];
            if (bit_end) begin
               if (idx_q == LAST_IDX) begin
                  stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else if (MSB_FIRST != 0) begin
                  idx_d = idx_q - IDX_W'(1);
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            line_d = par_q;
            if (bit_end) begin
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            line_d = LINE_IDLE;
            if (bit_end) begin
               if (stop_q == STOP_LAST) begin
                  done_d = 1'b1;
                  if (hold_full) begin
                     load    = 1'b1;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         stop_q     <= 1'b0;
         hold_q     <= '0;
         hold_full  <= 1'b0;
         shift_q    <= '0;
         tx         <= LINE_IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         stop_q     <= stop_d;
         tx         <= line_d;
         busy       <= (state_q != IDLE);
         frame_done <= done_d;
         // drain requires hold_full, accept requires !hold_full: never the same edge
         if (load) begin
            shift_q   <= hold_q;
            hold_full <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= (^hold_q) ^ (PARITY_ODD != 0);
`endif
         end else if (valid && !hold_full) begin
            hold_q    <= data;
            hold_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed vector bench for uart_tx_frame (LSB/8N1, MSB/2-stop and odd-parity instances).
module tb_uart_tx_frame;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct {
      int         inst;
      logic [7:0] word;
      string      bits;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] data_a [3];
   logic [2:0] valid = '0;
   logic [2:0] ready, tx, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .MSB_FIRST(0), .PARITY_ODD(0)) u_lsb (
      .clk(clk), .rst(rst), .data(data_a[0]), .valid(valid[0]),
      .ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(done[0]));

   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2), .MSB_FIRST(1), .PARITY_ODD(0)) u_msb (
      .clk(clk), .rst(rst), .data(data_a[1]), .valid(valid[1]),
      .ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(done[1]));

   uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .MSB_FIRST(0), .PARITY_ODD(1)) u_odd (
      .clk(clk), .rst(rst), .data(data_a[2]), .valid(valid[2]),
      .ready(ready[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(done[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Checks tx cycle by cycle from the first start-bit cycle; fl = bits per frame,
   // rr = first sample index at which ready is expected high.
   task automatic check_stream(input int inst, input string bits, input int fl, input int rr,
                               input bit jitter);
      for (int k = 0; k < bits.len() * CPB; k++) begin
         @(posedge clk); #1;
         chk("tx_bit", tx[inst], (bits.getc(k / CPB) == "1"));
         chk("frame_done", done[inst], (((k + 1) % (fl * CPB)) == 0));
         chk("busy", busy[inst], 1);
         chk("ready", ready[inst], (k >= rr));
         if (ready[inst] || !jitter) valid[inst] = 1'b0;
         else                        data_a[inst] = 8'($urandom);
      end
      @(posedge clk); #1;
      chk("tx_idle_after", tx[inst], 1);
      chk("busy_after", busy[inst], 0);
      chk("done_after", done[inst], 0);
   endtask

   task automatic one_frame(input int inst, input logic [7:0] w, input string bits);
      @(negedge clk);
      data_a[inst] = w;
      valid[inst]  = 1'b1;
      chk("ready_before", ready[inst], 1);
      @(posedge clk); #1;
      valid[inst] = 1'b0;
      chk("ready_held", ready[inst], 0);
      chk("tx_accept_edge", tx[inst], 1);
      @(posedge clk); #1;
      chk("ready_drained", ready[inst], 1);
      chk("tx_load_edge", tx[inst], 1);
      chk("busy_load_edge", busy[inst], 0);
      check_stream(inst, bits, bits.len(), 0, 1'b0);
   endtask

   task automatic two_frames(input logic [7:0] w1, input logic [7:0] w2,
                             input string s1, input string s2, input bit jitter);
      @(negedge clk);
      data_a[0] = w1;
      valid[0]  = 1'b1;
      @(posedge clk); #1;
      data_a[0] = w2;
      chk("b2b_hold1", ready[0], 0);
      @(posedge clk); #1;
      chk("b2b_drain1", ready[0], 1);
      chk("b2b_tx_load", tx[0], 1);
      check_stream(0, {s1, s2}, s1.len(), s1.len() * CPB - 1, jitter);
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{0, 8'hA5, PAR ? "01010010101"  : "0101001011"};
      vecs[1] = '{1, 8'hA5, PAR ? "010100101011" : "01010010111"};
      vecs[2] = '{2, 8'hA5, PAR ? "01010010111"  : "0101001011"};
      vecs[3] = '{0, 8'hFF, PAR ? "01111111101"  : "0111111111"};
      vecs[4] = '{1, 8'h01, PAR ? "000000001111" : "00000000111"};
      vecs[5] = '{2, 8'h3C, PAR ? "00011110011"  : "0001111001"};
      vecs[6] = '{0, 8'h00, PAR ? "00000000001"  : "0000000001"};
      for (int i = 0; i < 3; i++) data_a[i] = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx", tx, 3'b111);
      chk("rst_ready", ready, 3'b111);
      chk("rst_busy", busy, 3'b000);
      chk("rst_done", done, 3'b000);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) one_frame(vecs[i].inst, vecs[i].word, vecs[i].bits);

      two_frames(8'h01, 8'h80, PAR ? "01000000011" : "0100000001",
                 PAR ? "00000000111" : "0000000011", 1'b0);

      two_frames(8'hC3, 8'h5A, PAR ? "01100001101" : "0110000111",
                 PAR ? "00101101001" : "0010110101", 1'b1);

      // reset during data bit 3 of 0xFF
      @(negedge clk);
      data_a[0] = 8'hFF;
      valid[0]  = 1'b1;
      @(posedge clk); #1;
      valid[0] = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy[0], 1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_tx", tx[0], 1);
      chk("midrst_ready", ready[0], 1);
      chk("midrst_busy", busy[0], 0);
      chk("midrst_done", done[0], 0);
      repeat (2) begin
         @(posedge clk); #1;
         chk("midrst_done_hold", done[0], 0);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         chk("post_rst_tx", tx[0], 1);
         chk("post_rst_busy", busy[0], 0);
         chk("post_rst_done", done[0], 0);
      end
      one_frame(0, 8'h00, PAR ? "00000000001" : "0000000001");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
